// File: rtl/mcif_write_pkg.sv
// Shared definitions for the MCIF write path.
// Contents:
//   NUM_CLIENTS      number of DMA write clients; the client index is the AXI id
//   BDMA..RBK        client index constants
//   AXI_ID_W         AXI AW id width
//   cq_pd_t          completion-queue payload {len, require_ack}
//   rr_next          round-robin successor of a client index (wraps 4 -> 0)
//   rr_offset        client index 'k' places after 'base', modulo NUM_CLIENTS
package mcif_write_pkg;

   localparam int NUM_CLIENTS = 5;

   localparam logic [2:0] BDMA = 3'd0;
   localparam logic [2:0] SDP  = 3'd1;
   localparam logic [2:0] PDP  = 3'd2;
   localparam logic [2:0] CDP  = 3'd3;
   localparam logic [2:0] RBK  = 3'd4;

   localparam int AXI_ID_W = 8;

   typedef struct packed {
      logic [1:0] len;
      logic       require_ack;
   } cq_pd_t;

   function automatic logic [2:0] rr_next(input logic [2:0] idx);
      return (idx == RBK) ? BDMA : idx + 3'd1;
   endfunction

   // base is always a legal index (0..4) and k < 5, so one conditional
   // subtraction is enough to wrap.
   function automatic logic [2:0] rr_offset(input logic [2:0] base, input logic [2:0] k);
      logic [3:0] sum;
      sum = {1'b0, base} + {1'b0, k};
      if (sum >= 4'd5) sum = sum - 4'd5;
      return sum[2:0];
   endfunction

endpackage

// File: rtl/mcif_rr_arb5.sv
// Five-way round-robin arbiter, purely combinational.
// Ports:
//   elig     per-client eligibility
//   ptr      highest-priority client this cycle (0..4)
//   gnt      one-hot grant (all zero when nothing is eligible)
//   gnt_vld  any grant this cycle
//   gnt_idx  index of the granted client (0 when gnt_vld=0)
module mcif_rr_arb5
   import mcif_write_pkg::*;
(
   input  logic [NUM_CLIENTS-1:0] elig,
   input  logic [2:0]             ptr,
   output logic [NUM_CLIENTS-1:0] gnt,
   output logic                   gnt_vld,
   output logic [2:0]             gnt_idx
);

   logic [2:0] cand;

   // Walk the clients starting at ptr; the first eligible one wins.
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NUM_CLIENTS; k++) begin
         cand = rr_offset(ptr, 3'(k));
         if (!gnt_vld && elig[cand]) begin
            gnt[cand] = 1'b1;
            gnt_vld   = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mcif_write_ig_cq_tracker.sv
// MCIF write ingress: arbitrates five DMA write clients onto a single AXI AW
// register, pushes a {len, require_ack} entry into the granted client's
// completion queue, and tracks outstanding write beats with a credit pool
// that the egress side refills as write responses retire.
// Ports:
//   nvdla_core_clk / nvdla_core_rst   clock, async active-high reset
//   cmd{i}_vld/rdy/len/require_ack    client i write command (len = beats-1)
//   cq_wr{i}_pvld/prdy/pd             completion queue i push, pd={len,ack}
//   mcif2noc_axi_aw_*                 AXI AW channel (awid = client index)
//   eg2ig_axi_vld/len                 egress retired one write of len+1 beats
//   ig_os_idle                        no outstanding beats and AW register empty
//
// Handshakes: a command transfers in the cycle cmd{i}_rdy=1; rdy is only
// asserted when cmd{i}_vld=1 and the client wins arbitration, and the
// matching cq_wr{i}_pvld is asserted in the same cycle (only when
// cq_wr{i}_prdy=1, so the push always completes). AW follows AXI: the
// payload is held stable while awvalid=1 and awready=0 and the beat
// transfers on awvalid & awready.
module mcif_write_ig_cq_tracker #(
   parameter int NUM_CLIENTS = 5,
   parameter int OS_BEATS    = 32
) (
   input  logic       nvdla_core_clk,
   input  logic       nvdla_core_rst,
   input  logic       cmd0_vld,
   output logic       cmd0_rdy,
   input  logic [1:0] cmd0_len,
   input  logic       cmd0_require_ack,
   input  logic       cmd1_vld,
   output logic       cmd1_rdy,
   input  logic [1:0] cmd1_len,
   input  logic       cmd1_require_ack,
   input  logic       cmd2_vld,
   output logic       cmd2_rdy,
   input  logic [1:0] cmd2_len,
   input  logic       cmd2_require_ack,
   input  logic       cmd3_vld,
   output logic       cmd3_rdy,
   input  logic [1:0] cmd3_len,
   input  logic       cmd3_require_ack,
   input  logic       cmd4_vld,
   output logic       cmd4_rdy,
   input  logic [1:0] cmd4_len,
   input  logic       cmd4_require_ack,
   output logic       cq_wr0_pvld,
   input  logic       cq_wr0_prdy,
   output logic [2:0] cq_wr0_pd,
   output logic       cq_wr1_pvld,
   input  logic       cq_wr1_prdy,
   output logic [2:0] cq_wr1_pd,
   output logic       cq_wr2_pvld,
   input  logic       cq_wr2_prdy,
   output logic [2:0] cq_wr2_pd,
   output logic       cq_wr3_pvld,
   input  logic       cq_wr3_prdy,
   output logic [2:0] cq_wr3_pd,
   output logic       cq_wr4_pvld,
   input  logic       cq_wr4_prdy,
   output logic [2:0] cq_wr4_pd,
   output logic       mcif2noc_axi_aw_awvalid,
   input  logic       mcif2noc_axi_aw_awready,
   output logic [7:0] mcif2noc_axi_aw_awid,
   output logic [1:0] mcif2noc_axi_aw_awlen,
   input  logic       eg2ig_axi_vld,
   input  logic [1:0] eg2ig_axi_len,
   output logic       ig_os_idle
);

   import mcif_write_pkg::*;

   localparam int              CW        = $clog2(OS_BEATS + 1);
   localparam logic [CW-1:0]   CRED_FULL = CW'(OS_BEATS);
   localparam logic [CW:0]     CRED_MAX  = (CW+1)'(OS_BEATS);
   localparam logic [CW:0]     BEAT_ONE  = {{CW{1'b0}}, 1'b1};

   logic [NUM_CLIENTS-1:0] vld, prdy, ack, elig, gnt;
   logic [1:0]             len [NUM_CLIENTS];
   cq_pd_t                 pd  [NUM_CLIENTS];
   logic                   gnt_vld;
   logic [2:0]             gnt_idx;
   logic [2:0]             rr_ptr;
   logic [CW-1:0]          credits, credits_nxt;
   logic [CW:0]            ret_beats, take_beats, cred_sum;
   logic                   slot_free, overflow;

   assign vld  = {cmd4_vld, cmd3_vld, cmd2_vld, cmd1_vld, cmd0_vld};
   assign prdy = {cq_wr4_prdy, cq_wr3_prdy, cq_wr2_prdy, cq_wr1_prdy, cq_wr0_prdy};
   assign ack  = {cmd4_require_ack, cmd3_require_ack, cmd2_require_ack,
                  cmd1_require_ack, cmd0_require_ack};
   assign len[0] = cmd0_len;
   assign len[1] = cmd1_len;
   assign len[2] = cmd2_len;
   assign len[3] = cmd3_len;
   assign len[4] = cmd4_len;

   // The AW register can take a new command when empty or draining this cycle.
   assign slot_free = !mcif2noc_axi_aw_awvalid | mcif2noc_axi_aw_awready;

   // Credits are compared against the registered value only; a return in
   // this cycle becomes usable from the next cycle. Reset blocks every grant
   // so no rdy/pvld escapes while reset is held.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         elig[i] = !nvdla_core_rst & vld[i] & prdy[i] & slot_free &
                   ({1'b0, credits} >= ({{(CW-1){1'b0}}, len[i]} + BEAT_ONE));
      end
   end

   mcif_rr_arb5 u_arb (
      .elig    (elig),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx)
   );

   // Payload is forced to zero on lanes that are not pushing.
   always_comb begin
      for (int i = 0; i < NUM_CLIENTS; i++) begin
         pd[i].len         = gnt[i] ? len[i] : 2'b00;
         pd[i].require_ack = gnt[i] & ack[i];
      end
   end

   assign cmd0_rdy = gnt[0];
   assign cmd1_rdy = gnt[1];
   assign cmd2_rdy = gnt[2];
   assign cmd3_rdy = gnt[3];
   assign cmd4_rdy = gnt[4];
   assign cq_wr0_pvld = gnt[0];
   assign cq_wr1_pvld = gnt[1];
   assign cq_wr2_pvld = gnt[2];
   assign cq_wr3_pvld = gnt[3];
   assign cq_wr4_pvld = gnt[4];
   assign cq_wr0_pd = pd[0];
   assign cq_wr1_pd = pd[1];
   assign cq_wr2_pd = pd[2];
   assign cq_wr3_pd = pd[3];
   assign cq_wr4_pd = pd[4];

   // Net credit change: return and grant in the same cycle both apply.
   // A grant never exceeds the registered credits, so the sum cannot underflow.
   always_comb begin
      ret_beats   = eg2ig_axi_vld ? ({{(CW-1){1'b0}}, eg2ig_axi_len} + BEAT_ONE) : '0;
      take_beats  = gnt_vld ? ({{(CW-1){1'b0}}, len[gnt_idx]} + BEAT_ONE) : '0;
      cred_sum    = {1'b0, credits} + ret_beats - take_beats;
      overflow    = cred_sum > CRED_MAX;
      credits_nxt = overflow ? CRED_FULL : cred_sum[CW-1:0];
   end

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         mcif2noc_axi_aw_awvalid <= 1'b0;
         mcif2noc_axi_aw_awid    <= '0;
         mcif2noc_axi_aw_awlen   <= '0;
         rr_ptr                  <= BDMA;
         credits                 <= CRED_FULL;
      end else begin
         if (gnt_vld) begin
            mcif2noc_axi_aw_awvalid <= 1'b1;
            mcif2noc_axi_aw_awid    <= {{(AXI_ID_W-3){1'b0}}, gnt_idx};
            mcif2noc_axi_aw_awlen   <= len[gnt_idx];
            rr_ptr                  <= rr_next(gnt_idx);
         end else if (mcif2noc_axi_aw_awready) begin
            mcif2noc_axi_aw_awvalid <= 1'b0;
         end
         credits <= credits_nxt;
      end
   end

   assign ig_os_idle = (credits == CRED_FULL) & !mcif2noc_axi_aw_awvalid;

   // Egress returning more beats than were issued is a protocol error.
   a_credit_no_overflow : assert property (
      @(posedge nvdla_core_clk) disable iff (nvdla_core_rst) !overflow
   ) else $error("credit return overflow");

endmodule

// File: tb/tb_mcif_write_ig_cq_tracker.sv
// Self-checking bench for mcif_write_ig_cq_tracker.
module tb_mcif_write_ig_cq_tracker;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] cmd_vld;
   logic [4:0] req_ack;
   logic [4:0] cq_prdy;
   logic [1:0] cmd_len [5];
   wire  [4:0] cmd_rdy;
   wire  [4:0] cq_pvld;
   wire  [2:0] cq_pd [5];
   logic       awready;
   wire        awvalid;
   wire  [7:0] awid;
   wire  [1:0] awlen;
   logic       eg_vld;
   logic [1:0] eg_len;
   wire        idle;

   int checks = 0;
   int errors = 0;
   int mdl_credits = 32;

   logic [5:0] exp_q[$];   // {client, len, ack} expected per grant
   logic [9:0] aw_q[$];    // {awid, awlen} expected per AW handshake

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   mcif_write_ig_cq_tracker dut (
      .nvdla_core_clk          (clk),
      .nvdla_core_rst          (rst),
      .cmd0_vld (cmd_vld[0]), .cmd0_rdy (cmd_rdy[0]), .cmd0_len (cmd_len[0]), .cmd0_require_ack (req_ack[0]),
      .cmd1_vld (cmd_vld[1]), .cmd1_rdy (cmd_rdy[1]), .cmd1_len (cmd_len[1]), .cmd1_require_ack (req_ack[1]),
      .cmd2_vld (cmd_vld[2]), .cmd2_rdy (cmd_rdy[2]), .cmd2_len (cmd_len[2]), .cmd2_require_ack (req_ack[2]),
      .cmd3_vld (cmd_vld[3]), .cmd3_rdy (cmd_rdy[3]), .cmd3_len (cmd_len[3]), .cmd3_require_ack (req_ack[3]),
      .cmd4_vld (cmd_vld[4]), .cmd4_rdy (cmd_rdy[4]), .cmd4_len (cmd_len[4]), .cmd4_require_ack (req_ack[4]),
      .cq_wr0_pvld (cq_pvld[0]), .cq_wr0_prdy (cq_prdy[0]), .cq_wr0_pd (cq_pd[0]),
      .cq_wr1_pvld (cq_pvld[1]), .cq_wr1_prdy (cq_prdy[1]), .cq_wr1_pd (cq_pd[1]),
      .cq_wr2_pvld (cq_pvld[2]), .cq_wr2_prdy (cq_prdy[2]), .cq_wr2_pd (cq_pd[2]),
      .cq_wr3_pvld (cq_pvld[3]), .cq_wr3_prdy (cq_prdy[3]), .cq_wr3_pd (cq_pd[3]),
      .cq_wr4_pvld (cq_pvld[4]), .cq_wr4_prdy (cq_prdy[4]), .cq_wr4_pd (cq_pd[4]),
      .mcif2noc_axi_aw_awvalid (awvalid),
      .mcif2noc_axi_aw_awready (awready),
      .mcif2noc_axi_aw_awid    (awid),
      .mcif2noc_axi_aw_awlen   (awlen),
      .eg2ig_axi_vld           (eg_vld),
      .eg2ig_axi_len           (eg_len),
      .ig_os_idle              (idle)
   );

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int c, input int l, input logic a);
      exp_q.push_back({3'(c), 2'(l), a});
      aw_q.push_back({8'(c), 2'(l)});
      mdl_credits -= l + 1;
   endtask

   task automatic ret(input int l);
      eg_vld = 1'b1;
      eg_len = 2'(l);
      tick();
      eg_vld = 1'b0;
      mdl_credits += l + 1;
   endtask

   task automatic drain();
      int n;
      while (mdl_credits < 32) begin
         n = (32 - mdl_credits > 4) ? 4 : 32 - mdl_credits;
         ret(n - 1);
      end
      tick();
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [2:0] mon_gi;
   logic       mon_ok;
   logic [5:0] mon_e;
   logic [9:0] mon_aw;

   always @(negedge clk) begin
      if (!rst) begin
         if ((|cmd_rdy) || (|cq_pvld)) begin
            mon_gi = '0;
            for (int i = 0; i < 5; i++) if (cmd_rdy[i]) mon_gi = 3'(i);
            mon_ok = (cmd_rdy == cq_pvld) && $onehot(cmd_rdy);
            for (int i = 0; i < 5; i++) if (3'(i) != mon_gi && cq_pd[i] != 3'b000) mon_ok = 1'b0;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL grant_unexpected got client=%0d pd=%03b exp none", mon_gi, cq_pd[mon_gi]);
            end else begin
               mon_e = exp_q.pop_front();
               if (!mon_ok || {mon_gi, cq_pd[mon_gi]} != mon_e) begin
                  errors++;
                  $display("FAIL grant got ok=%0d client=%0d pd=%03b exp client=%0d pd=%03b",
                           mon_ok, mon_gi, cq_pd[mon_gi], mon_e[5:3], mon_e[2:0]);
               end
            end
         end
         if (awvalid && awready) begin
            checks++;
            if (aw_q.size() == 0) begin
               errors++;
               $display("FAIL aw_unexpected got awid=%0d awlen=%0d exp none", awid, awlen);
            end else begin
               mon_aw = aw_q.pop_front();
               if ({awid, awlen} != mon_aw) begin
                  errors++;
                  $display("FAIL aw got awid=%0d awlen=%0d exp awid=%0d awlen=%0d",
                           awid, awlen, mon_aw[9:2], mon_aw[1:0]);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      cmd_vld = '0;
      req_ack = '0;
      cq_prdy = 5'b11111;
      for (int i = 0; i < 5; i++) cmd_len[i] = 2'd0;
      awready = 1'b1;
      eg_vld  = 1'b0;
      eg_len  = 2'd0;

      // Reset: every client requesting, nothing may be granted.
      cmd_vld = 5'b11111;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_cmd_rdy", 32'(cmd_rdy), 32'h0);
      check("reset_pvld", 32'(cq_pvld), 32'h0);
      check("reset_awvalid", 32'(awvalid), 32'h0);
      check("reset_awid", 32'(awid), 32'h0);
      check("reset_awlen", 32'(awlen), 32'h0);
      check("reset_idle", 32'(idle), 32'h1);
      cmd_vld = '0;
      @(posedge clk);
      #1 rst = 1'b0;

      // Single command: cmd1 len=2 ack=1.
      cmd_len[1] = 2'd2; req_ack[1] = 1'b1; cmd_vld[1] = 1'b1;
      push_exp(1, 2, 1'b1);
      @(negedge clk);
      check("single_rdy", 32'(cmd_rdy), 32'h02);
      check("single_pd", 32'(cq_pd[1]), 32'h5);
      tick();
      cmd_vld = '0;
      check("single_awvalid", 32'(awvalid), 32'h1);
      check("single_awid", 32'(awid), 32'h1);
      check("single_awlen", 32'(awlen), 32'h2);
      check("single_idle_busy", 32'(idle), 32'h0);
      ret(2);
      check("single_idle_back", 32'(idle), 32'h1);

      // Round robin: pointer is now 2; all five valid for six cycles.
      cmd_len[0] = 2'd0; cmd_len[1] = 2'd1; cmd_len[2] = 2'd2; cmd_len[3] = 2'd3; cmd_len[4] = 2'd0;
      req_ack = 5'b10101;
      push_exp(2, 2, 1'b1);
      push_exp(3, 3, 1'b0);
      push_exp(4, 0, 1'b1);
      push_exp(0, 0, 1'b1);
      push_exp(1, 1, 1'b0);
      push_exp(2, 2, 1'b1);
      cmd_vld = 5'b11111;
      repeat (6) tick();
      cmd_vld = '0;
      check("rr_all_granted", 32'(exp_q.size()), 32'h0);
      drain();
      check("rr_idle", 32'(idle), 32'h1);

      // Credit starvation: eight len=3 grants exhaust 32 credits.
      cmd_len[0] = 2'd3; req_ack[0] = 1'b0;
      repeat (8) push_exp(0, 3, 1'b0);
      cmd_vld = 5'b00001;
      repeat (8) tick();
      cmd_vld = '0;
      cmd_len[2] = 2'd0; req_ack[2] = 1'b1; cmd_vld[2] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("starve_no_grant", 32'(cmd_rdy), 32'h0);
         check("starve_idle_busy", 32'(idle), 32'h0);
         @(posedge clk); #1;
      end
      eg_vld = 1'b1; eg_len = 2'd0;
      @(negedge clk);
      check("starve_same_cycle_return", 32'(cmd_rdy), 32'h0);
      @(posedge clk); #1;
      eg_vld = 1'b0;
      mdl_credits += 1;
      push_exp(2, 0, 1'b1);
      @(negedge clk);
      check("starve_grant_after_return", 32'(cmd_rdy), 32'h04);
      @(posedge clk); #1;
      cmd_vld = '0;
      drain();
      check("starve_idle", 32'(idle), 32'h1);

      // AW backpressure: load cmd1 with awready=0, then cmd3 must wait.
      awready = 1'b0;
      cmd_len[1] = 2'd2; req_ack[1] = 1'b0; cmd_vld = 5'b00010;
      push_exp(1, 2, 1'b0);
      tick();
      cmd_len[3] = 2'd1; req_ack[3] = 1'b1; cmd_vld = 5'b01000;
      repeat (3) begin
         @(negedge clk);
         check("bp_rdy_held", 32'(cmd_rdy), 32'h0);
         check("bp_awvalid", 32'(awvalid), 32'h1);
         check("bp_awid", 32'(awid), 32'h1);
         check("bp_awlen", 32'(awlen), 32'h2);
         @(posedge clk); #1;
      end
      awready = 1'b1;
      push_exp(3, 1, 1'b1);
      @(negedge clk);
      check("bp_grant_on_ready", 32'(cmd_rdy), 32'h08);
      @(posedge clk); #1;
      cmd_vld = '0;
      check("bp_awid_next", 32'(awid), 32'h3);
      check("bp_awlen_next", 32'(awlen), 32'h1);
      tick();
      drain();

      // CQ full: move pointer to 0 with a lone cmd4 grant, then block cq0.
      cmd_len[4] = 2'd0; req_ack[4] = 1'b0; cmd_vld = 5'b10000;
      push_exp(4, 0, 1'b0);
      tick();
      cq_prdy = 5'b11110;
      cmd_len[0] = 2'd1; req_ack[0] = 1'b1;
      cmd_len[4] = 2'd2; req_ack[4] = 1'b1;
      cmd_vld = 5'b10001;
      push_exp(4, 2, 1'b1);
      @(negedge clk);
      check("cqfull_skip", 32'(cmd_rdy), 32'h10);
      @(posedge clk); #1;
      cmd_vld = 5'b00001;
      @(negedge clk);
      check("cqfull_blocked", 32'(cmd_rdy), 32'h0);
      @(posedge clk); #1;
      cq_prdy = 5'b11111;
      push_exp(0, 1, 1'b1);
      @(negedge clk);
      check("cqfull_grant", 32'(cmd_rdy), 32'h01);
      @(posedge clk); #1;
      cmd_vld = '0;
      drain();

      // Reset mid-operation: 12 beats out (credits 20), AW held by awready=0.
      cmd_len[0] = 2'd3; req_ack[0] = 1'b0;
      repeat (3) push_exp(0, 3, 1'b0);
      cmd_vld = 5'b00001;
      repeat (3) tick();
      cmd_vld = '0;
      awready = 1'b0;
      check("midrst_pre_awvalid", 32'(awvalid), 32'h1);
      check("midrst_pre_idle", 32'(idle), 32'h0);
      #2;
      cmd_vld = 5'b11111;
      rst = 1'b1;
      #1;
      check("midrst_awvalid", 32'(awvalid), 32'h0);
      check("midrst_awid", 32'(awid), 32'h0);
      check("midrst_idle", 32'(idle), 32'h1);
      check("midrst_rdy_gated", 32'(cmd_rdy), 32'h0);
      aw_q.delete();
      mdl_credits = 32;
      @(posedge clk); #1;
      awready = 1'b1;
      push_exp(0, 3, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("midrst_ptr_zero", 32'(cmd_rdy), 32'h01);
      @(posedge clk); #1;
      cmd_vld = '0;
      tick();
      drain();
      check("final_idle", 32'(idle), 32'h1);
      check("final_exp_q_empty", 32'(exp_q.size()), 32'h0);
      check("final_aw_q_empty", 32'(aw_q.size()), 32'h0);

      // ---------------- report ----------------
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
